// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encoding and default sizing for the pipeline freeze/flush sequencer.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer for the 5-stage pipeline: memory stall, branch flush,
// load-use bubble, memory timeout detection and saturating statistics.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             bubble_wb,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int            TW       = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          mem_stall;
  logic          mem_freeze_act;
  logic          branch_act;
  logic          hazard_act;

  assign mem_stall = (mem_req && !mem_ready) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // priority chain can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    tcnt_d         = '0;
    freeze_if      = 1'b0;
    freeze_id      = 1'b0;
    freeze_exe     = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_exe   = 1'b0;
    bubble_wb      = 1'b0;
    mem_freeze_act = 1'b0;
    branch_act     = 1'b0;
    hazard_act     = 1'b0;

    if ((state_q == ST_ERROR) || mem_stall) begin
      freeze_if      = 1'b1;
      freeze_id      = 1'b1;
      freeze_exe     = 1'b1;
      bubble_wb      = 1'b1;
      mem_freeze_act = 1'b1;
    end else if (branch_taken) begin
      // The hazarding instruction is squashed by the flush, so hazard is moot.
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
      branch_act   = 1'b1;
    end else if (hazard) begin
      freeze_if    = 1'b1;
      flush_id_exe = 1'b1;
      hazard_act   = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (mem_stall) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // A completion arriving on the limit cycle still wins over the timeout.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (tcnt_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  assign mem_error = (state_q == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard_act),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_freeze_act),
    .count (memwait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_act),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: two controller instances (default sizing and a small
// timeout/counter variant) share one random+directed stimulus stream.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard, branch_taken, mem_req, mem_ready;

  logic        a_fif, a_fid, a_fexe, a_flif, a_flid, a_bwb, a_err;
  logic [15:0] a_stall, a_memw, a_flush;
  logic        b_fif, b_fid, b_fexe, b_flif, b_flid, b_bwb, b_err;
  logic [2:0]  b_stall, b_memw, b_flush;

  pipeline_stall_controller #(.MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(a_fif), .freeze_id(a_fid), .freeze_exe(a_fexe),
    .flush_if_id(a_flif), .flush_id_exe(a_flid), .bubble_wb(a_bwb),
    .mem_error(a_err), .stall_cnt(a_stall), .memwait_cnt(a_memw), .flush_cnt(a_flush)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(b_fif), .freeze_id(b_fid), .freeze_exe(b_fexe),
    .flush_if_id(b_flif), .flush_id_exe(b_flid), .bubble_wb(b_bwb),
    .mem_error(b_err), .stall_cnt(b_stall), .memwait_cnt(b_memw), .flush_cnt(b_flush)
  );

  // Behavioural model: pipeline is either flowing, waiting on memory for some
  // number of elapsed wait cycles, or dead until reset.
  typedef struct {
    bit waiting;
    bit errored;
    int waited;
    int stalls;
    int memwaits;
    int flushes;
  } model_t;

  // ctrl = {freeze_if, freeze_id, freeze_exe, flush_if_id, flush_id_exe, bubble_wb}
  typedef struct {
    logic [5:0] ctrl;
    logic       err;
    int         stall;
    int         memw;
    int         flush;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  function automatic int sat_inc(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_cycle(inout model_t m, input int tmo, input int w,
                             input bit r, input bit h, input bit b, input bit q,
                             input bit y, output exp_t e);
    bit stalled;
    e.ctrl  = 6'b0;
    e.err   = m.errored;
    e.stall = m.stalls;
    e.memw  = m.memwaits;
    e.flush = m.flushes;
    stalled = !m.errored && ((q && !y) || (m.waiting && !y));
    if (m.errored || stalled) begin
      e.ctrl     = 6'b111001;
      m.memwaits = sat_inc(m.memwaits, w);
    end else if (b) begin
      e.ctrl    = 6'b000110;
      m.flushes = sat_inc(m.flushes, w);
    end else if (h) begin
      e.ctrl   = 6'b100010;
      m.stalls = sat_inc(m.stalls, w);
    end
    if (r) begin
      m = '{default: 0};
    end else if (!m.errored) begin
      if (stalled) begin
        if (m.waiting) m.waited++;
        if (m.waited == tmo) begin
          m.errored = 1'b1;
          m.waiting = 1'b0;
        end else begin
          m.waiting = 1'b1;
        end
      end else begin
        m.waiting = 1'b0;
        m.waited  = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit h, input bit b, input bit q, input bit y);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = r; hazard = h; branch_taken = b; mem_req = q; mem_ready = y;
    model_cycle(ma, 64, 16, r, h, b, q, y, ea);
    model_cycle(mb, 4, 3, r, h, b, q, y, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic repeat_step(input int n, input bit r, input bit h, input bit b,
                             input bit q, input bit y);
    for (int i = 0; i < n; i++) step(r, h, b, q, y);
  endtask

  // Monitor: every cycle the DUTs present a full control word; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_ctrl", 32'({a_fif, a_fid, a_fexe, a_flif, a_flid, a_bwb}), 32'(e.ctrl));
        check("a_mem_error", 32'(a_err), 32'(e.err));
        check("a_stall_cnt", 32'(a_stall), e.stall);
        check("a_memwait_cnt", 32'(a_memw), e.memw);
        check("a_flush_cnt", 32'(a_flush), e.flush);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_ctrl", 32'({b_fif, b_fid, b_fexe, b_flif, b_flid, b_bwb}), 32'(e.ctrl));
        check("b_mem_error", 32'(b_err), 32'(e.err));
        check("b_stall_cnt", 32'(b_stall), e.stall);
        check("b_memwait_cnt", 32'(b_memw), e.memw);
        check("b_flush_cnt", 32'(b_flush), e.flush);
      end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};

    repeat_step(2, 1, 0, 0, 0, 0);            // reset state
    repeat_step(2, 0, 1, 0, 0, 0);            // load-use hazard bubbles
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);                      // branch beats hazard
    step(0, 0, 0, 0, 0);
    repeat_step(3, 0, 0, 0, 1, 0);            // memory wait released by ready
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);                      // ready on first request cycle
    repeat_step(2, 0, 1, 1, 1, 0);            // stall masks branch and hazard
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);                      // short timeout into ERROR
    repeat_step(6, 0, 0, 0, 1, 0);
    repeat_step(2, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat_step(2, 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);                      // ready exactly on the limit cycle
    repeat_step(3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);                      // counter saturation
    repeat_step(10, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);                      // default timeout, then reset in ERROR
    repeat_step(70, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0);
    repeat_step(2, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
           $urandom_range(2) == 0, $urandom_range(1) == 0);
    end

    repeat (3) @(posedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
